// File: rtl/prog_rom1_1.sv
// -----------------------------------------------------------------------------
// prog_rom1_1
// Synchronous-read program ROM for the 18-bit RAT-style MCU.
//
// Holds a fixed 1024 x 18 program image. The program counter presents an
// address, and the instruction word is returned one clock later from an
// output register. The memory cannot be written.
//
// Ports
//   PROG_CLK   in   1            system clock, rising-edge active
//   RST        in   1            synchronous, active-high reset (clears PROG_IR)
//   PROG_ADDR  in   ADDR_WIDTH   instruction address from the program counter
//   PROG_IR    out  DATA_WIDTH   registered instruction word
// -----------------------------------------------------------------------------
module prog_rom1_1 #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  PROG_CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] PROG_ADDR,
  output logic [DATA_WIDTH-1:0] PROG_IR
);

  // Program image. The code begins at 0x40, the MCU reset vector; every other
  // location holds zero. The default branch covers the whole remaining
  // address space, so the decode is complete and needs no external file.
  function automatic logic [DATA_WIDTH-1:0] rom_word(
    input logic [ADDR_WIDTH-1:0] addr
  );
    logic [DATA_WIDTH-1:0] word;
    word = '0;
    case (int'(addr))
      'h040:   word = DATA_WIDTH'(18'h36105);
      'h041:   word = DATA_WIDTH'(18'h36203);
      'h042:   word = DATA_WIDTH'(18'h02108);
      'h043:   word = DATA_WIDTH'(18'h34120);
      'h044:   word = DATA_WIDTH'(18'h2A0A0);
      'h045:   word = DATA_WIDTH'(18'h08218);
      'h046:   word = DATA_WIDTH'(18'h08200);
      default: word = '0;
    endcase
    return word;
  endfunction

  // The declaration initialiser gives the power-up value (same as reset),
  // which FPGA flows honour for registers.
  logic [DATA_WIDTH-1:0] prog_ir_q = '0;

  // Only the output register is reset; the ROM image is constant and is left
  // untouched so the tools can still map it onto block or LUT ROM.
  // NOTE: non-blocking assignment keeps the register update race-free against
  // other clocked logic sampling PROG_IR on the same edge.
  always_ff @(posedge PROG_CLK) begin
    if (RST) begin
      prog_ir_q <= '0;
    end else begin
      prog_ir_q <= rom_word(PROG_ADDR);
    end
  end

  // Straight from the register: no combinational path from PROG_ADDR.
  assign PROG_IR = prog_ir_q;

endmodule

// File: tb/tb_prog_rom1_1.sv
// -----------------------------------------------------------------------------
// tb_prog_rom1_1
// Self-checking bench for prog_rom1_1. Each directed step drives PROG_ADDR/RST
// while the clock is low, pushes the word the ROM must return onto a queue,
// and after the following rising edge pops it and compares it with PROG_IR.
// -----------------------------------------------------------------------------
module tb_prog_rom1_1;

  localparam int AW = 10;
  localparam int DW = 18;

  logic          prog_clk = 1'b0;
  logic          rst      = 1'b1;
  logic [AW-1:0] prog_addr = 10'h040;
  logic [DW-1:0] prog_ir;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];

  prog_rom1_1 #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .PROG_CLK (prog_clk),
    .RST      (rst),
    .PROG_ADDR(prog_addr),
    .PROG_IR  (prog_ir)
  );

  always #5 prog_clk = ~prog_clk;  // 10 ns period

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference program image, written out independently of the RTL.
  function automatic logic [DW-1:0] ref_rom(input logic [AW-1:0] a);
    case (a)
      10'h040: return 18'h36105;
      10'h041: return 18'h36203;
      10'h042: return 18'h02108;
      10'h043: return 18'h34120;
      10'h044: return 18'h2A0A0;
      10'h045: return 18'h08218;
      10'h046: return 18'h08200;
      default: return 18'h00000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected word and compare it with PROG_IR.
  task automatic check_next(input string tag);
    logic [DW-1:0] exp;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      exp = exp_q.pop_front();
      check(tag, prog_ir, exp);
    end
  endtask

  // Apply inputs while the clock is low, record the expectation, then
  // compare 1 ns after the rising edge that loads PROG_IR.
  task automatic step(input string tag, input logic [AW-1:0] a, input logic r);
    @(negedge prog_clk);
    prog_addr = a;
    rst       = r;
    exp_q.push_back(r ? 18'h00000 : ref_rom(a));
    @(posedge prog_clk);
    #1;
    check_next(tag);
  endtask

  initial begin
    logic [DW-1:0] held;

    // Power-up value before the first rising edge.
    #1;
    check("power_up", prog_ir, 18'h00000);

    // 1. Reset held for two cycles with the reset vector on the address bus.
    step("reset_0", 10'h040, 1'b1);
    step("reset_1", 10'h040, 1'b1);
    step("first_fetch", 10'h040, 1'b0);

    // 2. Sequential fetch through the program.
    for (int i = 1; i <= 6; i++) begin
      step($sformatf("seq_%02h", 10'h040 + i), AW'(10'h040 + i), 1'b0);
    end

    // 3. Repeated address: same word on both edges and steady in between.
    step("hold_a", 10'h044, 1'b0);
    @(negedge prog_clk);
    #2;
    check("hold_mid", prog_ir, 18'h2A0A0);
    step("hold_b", 10'h044, 1'b0);

    // 4. Mid-cycle address changes must not reach PROG_IR before the edge.
    step("mid_base", 10'h041, 1'b0);
    prog_addr = 10'h045;  // clock high: change just after the edge
    #2;
    check("mid_high", prog_ir, 18'h36203);
    @(negedge prog_clk);
    prog_addr = 10'h042;  // clock low
    exp_q.push_back(ref_rom(10'h042));
    #2;
    check("mid_low", prog_ir, 18'h36203);
    @(posedge prog_clk);
    #1;
    check_next("mid_after");

    // 5. Unprogrammed and boundary addresses read as zero.
    step("addr_000", 10'h000, 1'b0);
    step("addr_03f", 10'h03F, 1'b0);
    step("addr_047", 10'h047, 1'b0);
    step("addr_3ff", 10'h3FF, 1'b0);

    // 6. Reset asserted mid-stream wins over the read, then fetch resumes.
    step("stream_40", 10'h040, 1'b0);
    step("stream_41", 10'h041, 1'b0);
    step("stream_42", 10'h042, 1'b0);
    step("stream_rst", 10'h043, 1'b1);
    step("stream_43", 10'h043, 1'b0);
    step("stream_44", 10'h044, 1'b0);

    // A few scattered addresses, including program words, against the model.
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      a = (i[0]) ? AW'($urandom_range(10'h040, 10'h046))
                 : AW'($urandom_range(0, 10'h3FF));
      step($sformatf("rand_%03h", a), a, 1'b0);
    end

    // Output holds across an idle half-cycle after the last read.
    held = ref_rom(prog_addr);
    @(negedge prog_clk);
    #2;
    check("final_hold", prog_ir, held);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
